// File: rtl/core_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package core_ifu_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_byte_t;

  localparam inst_byte_t INST_NOP  = 32'h0000_0013;
  localparam inst_addr_t ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } ifu_state_e;

  typedef struct packed {
    inst_addr_t addr;
    inst_byte_t inst;
  } fetch_entry_t;

  function automatic inst_addr_t word_align(input inst_addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_ifu_fifo.sv
// Synchronous fetch buffer of {addr, inst} entries; flush overrides push and pop.
module core_ifu_fifo
  import core_ifu_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [63:0]   push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic [63:0]   head_data
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = fetch_entry_t'(push_data);
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/core_ifu.sv
// Instruction fetch unit: PC, single-outstanding req/gnt/rvalid fetch FSM and
// a small buffer presenting {inst, inst_addr} downstream via valid/ready.
module core_ifu
  import core_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_gnt_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out,
  output logic        inst_valid_out,
  input  logic        inst_ready_in
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e    state_q, state_d;
  inst_addr_t    pc_q, pc_d;
  inst_addr_t    fetch_addr_q, fetch_addr_d;
  logic          discard_q, discard_d;
  logic          mem_req_q, mem_req_d;
  inst_addr_t    mem_addr_q, mem_addr_d;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CW-1:0] fifo_count, cnt_after_pop;
  logic [63:0]   fifo_head;
  fetch_entry_t  head;

  core_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({fetch_addr_q, mem_rdata_in}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  assign head           = fetch_entry_t'(fifo_head);
  assign inst_valid_out = !fifo_empty;
  assign inst_out       = fifo_empty ? INST_NOP  : head.inst;
  assign inst_addr_out  = fifo_empty ? ZERO_WORD : head.addr;
  assign mem_req_out    = mem_req_q;
  assign mem_addr_out   = mem_addr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    discard_d     = discard_q;
    fifo_push     = 1'b0;
    fifo_flush    = jump_flag_in;
    fifo_pop      = inst_valid_out & inst_ready_in;
    cnt_after_pop = fifo_count - CW'(fifo_pop);
    if (jump_flag_in) begin
      pc_d = word_align(jump_addr_in);
      unique case (state_q)
        IFU_REQ: begin
          if (mem_gnt_in) begin
            state_d   = IFU_WAIT;
            discard_d = 1'b1;
          end
        end
        IFU_WAIT: begin
          if (mem_rvalid_in) begin
            state_d   = IFU_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = IFU_REQ;
      endcase
    end else begin
      unique case (state_q)
        IFU_IDLE: begin
          if (fifo_count < CW'(FIFO_DEPTH)) state_d = IFU_REQ;
        end
        IFU_REQ: begin
          if (mem_gnt_in) begin
            fetch_addr_d = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (mem_rvalid_in) begin
            discard_d = 1'b0;
            fifo_push = !discard_q;
            state_d   = ((cnt_after_pop + CW'(fifo_push)) < CW'(FIFO_DEPTH))
                        ? IFU_REQ : IFU_IDLE;
          end
        end
        default: state_d = IFU_IDLE;
      endcase
    end
    // Bus outputs are registered from the next state so they track the FSM exactly.
    mem_req_d  = (state_d == IFU_REQ);
    mem_addr_d = pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IFU_IDLE;
      pc_q         <= RESET_ADDR;
      fetch_addr_q <= RESET_ADDR;
      discard_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_ADDR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      discard_q    <= discard_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

endmodule
